// File: rtl/dmx_pkg.sv
// dmx_pkg: shared constants, the arbiter state type and the channel-address
// legality check for the DMX512 transmitter write-port arbiter.
package dmx_pkg;

  localparam int DMX_CHANNELS = 512;
  localparam int DMX_ADDR_W   = 10;
  localparam int DMX_DATA_W   = 8;
  localparam int GRANT_W      = 3;

  localparam logic [DMX_ADDR_W-1:0] DMX_MAX_ADDR = DMX_ADDR_W'(DMX_CHANNELS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BURST    = 2'd1,
    BLACKOUT = 2'd2
  } arb_state_t;

  // Channel 0 is the DMX start code slot and is never addressed by the
  // write port; legal channels are 1..512.
  function automatic logic addr_legal(input logic [DMX_ADDR_W-1:0] addr);
    return (addr != '0) && (addr <= DMX_MAX_ADDR);
  endfunction

endpackage

// File: rtl/dmx_rr_arbiter.sv
// dmx_rr_arbiter: combinational round-robin pick.
//   valid     - per-requester request vector
//   rr_ptr    - index of the most recently served requester
//   winner    - first valid index searching upward from rr_ptr+1, with wrap
//   any_valid - at least one request is present
module dmx_rr_arbiter
  import dmx_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [GRANT_W-1:0] rr_ptr,
  output logic [GRANT_W-1:0] winner,
  output logic               any_valid
);

  logic found;

  always_comb begin
    winner    = rr_ptr;
    found     = 1'b0;
    any_valid = |valid;
    // Offset 1..NUM_REQ: the last-served requester is considered last.
    for (int i = 1; i <= NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && valid[j] && (((int'(rr_ptr) + i) % NUM_REQ) == j)) begin
          winner = GRANT_W'(j);
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dmx_write_arbiter.sv
// dmx_write_arbiter: shares the DMX512 transmitter channel write port among
// NUM_REQ requesters, granting whole bursts round-robin, and runs a
// priority blackout sweep that writes zero to channels 1..512.
//
// Ports
//   clk, rst                    clock; asynchronous active-high reset
//   req_valid/addr/data/last    per-requester byte stream
//   req_ready                   per-requester accept (valid & ready)
//   blackout                    single-cycle blackout request
//   blackout_busy               blackout pending or running
//   write_addr/data/en          registered transmitter write port
//   grant_id                    current or last granted requester
//   busy                        arbiter not in IDLE
//   err_addr                    pulse: illegal-address byte was accepted
//
// state    | meaning
// IDLE     | arbitrate; blackout takes priority over requesters
// BURST    | grant_id owns the port until last byte or idle timeout
// BLACKOUT | sweep zero into channels 1..512, one per cycle
module dmx_write_arbiter
  import dmx_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][DMX_ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][DMX_DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]                  req_last,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic                                blackout,
  output logic                                blackout_busy,
  output logic [DMX_ADDR_W-1:0]               write_addr,
  output logic [DMX_DATA_W-1:0]               write_data,
  output logic                                write_en,
  output logic [GRANT_W-1:0]                  grant_id,
  output logic                                busy,
  output logic                                err_addr
);

  localparam int TW = $clog2(TIMEOUT + 1);
  // Down-counter: reaching zero while still idle means TIMEOUT idle cycles.
  localparam logic [TW-1:0]      IDLE_LOAD = TW'(TIMEOUT - 1);
  localparam logic [GRANT_W-1:0] RR_RESET  = GRANT_W'(NUM_REQ - 1);

  arb_state_t              state, state_nxt;
  logic [GRANT_W-1:0]      grant_q, grant_nxt;
  logic [GRANT_W-1:0]      rr_ptr, rr_ptr_nxt;
  logic [TW-1:0]           idle_left, idle_left_nxt;
  logic [DMX_ADDR_W-1:0]   bo_cnt, bo_cnt_nxt;
  logic                    bo_pending, bo_pending_nxt;

  logic [GRANT_W-1:0]      win_id;
  logic                    any_valid;
  logic                    xfer;
  logic [DMX_ADDR_W-1:0]   sel_addr;
  logic [DMX_DATA_W-1:0]   sel_data;
  logic                    sel_last;

  dmx_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .valid     (req_valid),
    .rr_ptr    (rr_ptr),
    .winner    (win_id),
    .any_valid (any_valid)
  );

  always_comb begin
    req_ready = '0;
    sel_addr  = '0;
    sel_data  = '0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == GRANT_W'(i)) begin
        req_ready[i] = (state == BURST);
        sel_addr     = req_addr[i];
        sel_data     = req_data[i];
        sel_last     = req_last[i];
      end
    end
  end

  assign xfer          = |(req_ready & req_valid);
  assign busy          = (state != IDLE);
  assign blackout_busy = bo_pending || (state == BLACKOUT);
  assign grant_id      = grant_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant_q    <= '0;
      rr_ptr     <= RR_RESET;
      idle_left  <= IDLE_LOAD;
      bo_cnt     <= '0;
      bo_pending <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant_q    <= grant_nxt;
      rr_ptr     <= rr_ptr_nxt;
      idle_left  <= idle_left_nxt;
      bo_cnt     <= bo_cnt_nxt;
      bo_pending <= bo_pending_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant_q;
    rr_ptr_nxt     = rr_ptr;
    idle_left_nxt  = idle_left;
    bo_cnt_nxt     = bo_cnt;
    bo_pending_nxt = bo_pending;
    case (state)
      IDLE: begin
        // Checking the live pulse too lets a blackout beat a request
        // arriving in the same cycle.
        if (blackout || bo_pending) begin
          state_nxt      = BLACKOUT;
          bo_pending_nxt = 1'b0;
          bo_cnt_nxt     = DMX_ADDR_W'(1);
        end else if (any_valid) begin
          state_nxt     = BURST;
          grant_nxt     = win_id;
          idle_left_nxt = IDLE_LOAD;
        end
      end
      BURST: begin
        if (blackout) bo_pending_nxt = 1'b1;
        if (xfer) begin
          idle_left_nxt = IDLE_LOAD;
          if (sel_last) begin
            rr_ptr_nxt = grant_q;
            state_nxt  = IDLE;
          end
        end else if (idle_left == '0) begin
          rr_ptr_nxt = grant_q;
          state_nxt  = IDLE;
        end else begin
          idle_left_nxt = idle_left - TW'(1);
        end
      end
      BLACKOUT: begin
        if (bo_cnt == DMX_MAX_ADDR) state_nxt = IDLE;
        else                        bo_cnt_nxt = bo_cnt + DMX_ADDR_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      err_addr   <= 1'b0;
    end else begin
      write_en <= 1'b0;
      err_addr <= 1'b0;
      if (state == BLACKOUT) begin
        write_en   <= 1'b1;
        write_addr <= bo_cnt;
        write_data <= '0;
      end else if (xfer) begin
        if (addr_legal(sel_addr)) begin
          write_en   <= 1'b1;
          write_addr <= sel_addr;
          write_data <= sel_data;
        end else begin
          err_addr <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmx_write_arbiter.sv
// tb_dmx_write_arbiter: directed bench for dmx_write_arbiter. Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_dmx_write_arbiter;
  import dmx_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req_valid;
  logic [3:0][9:0] req_addr;
  logic [3:0][7:0] req_data;
  logic [3:0]      req_last;
  logic [3:0]      req_ready;
  logic            blackout;
  logic            blackout_busy;
  logic [9:0]      write_addr;
  logic [7:0]      write_data;
  logic            write_en;
  logic [2:0]      grant_id;
  logic            busy;
  logic            err_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmx_write_arbiter #(.NUM_REQ(4), .TIMEOUT(256)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .blackout      (blackout),
    .blackout_busy (blackout_busy),
    .write_addr    (write_addr),
    .write_data    (write_data),
    .write_en      (write_en),
    .grant_id      (grant_id),
    .busy          (busy),
    .err_addr      (err_addr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic [9:0] addr;
    logic [7:0] data;
    logic [3:0] ready;
    logic       we;
    logic [9:0] waddr;
    logic [7:0] wdata;
    logic       err;
    logic       busy;
    logic [2:0] grant;
  } vec_t;

  vec_t vecs[15];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int        grants, wcount, n, stray, sweep_bad;
    logic      found;
    logic [2:0] got[6];
    logic [2:0] exp_rot[6];
    logic [3:0] pend;
    int        cnt[4];
    logic      prev_busy;

    // valid  last   addr  data | ready  we waddr wdata err busy grant
    vecs[0]  = '{4'b0010, 4'b0000, 10'd5,   8'h10, 4'b0010, 1'b0, 10'd0,   8'h00, 1'b0, 1'b1, 3'd1};
    vecs[1]  = '{4'b0010, 4'b0000, 10'd5,   8'h10, 4'b0010, 1'b1, 10'd5,   8'h10, 1'b0, 1'b1, 3'd1};
    vecs[2]  = '{4'b0010, 4'b0000, 10'd6,   8'h20, 4'b0010, 1'b1, 10'd6,   8'h20, 1'b0, 1'b1, 3'd1};
    vecs[3]  = '{4'b0010, 4'b0010, 10'd7,   8'h30, 4'b0000, 1'b1, 10'd7,   8'h30, 1'b0, 1'b0, 3'd1};
    vecs[4]  = '{4'b0000, 4'b0000, 10'd0,   8'h00, 4'b0000, 1'b0, 10'd0,   8'h00, 1'b0, 1'b0, 3'd1};
    vecs[5]  = '{4'b0001, 4'b0000, 10'd0,   8'h55, 4'b0001, 1'b0, 10'd0,   8'h00, 1'b0, 1'b1, 3'd0};
    vecs[6]  = '{4'b0001, 4'b0000, 10'd0,   8'h55, 4'b0001, 1'b0, 10'd0,   8'h00, 1'b1, 1'b1, 3'd0};
    vecs[7]  = '{4'b0001, 4'b0000, 10'd513, 8'h66, 4'b0001, 1'b0, 10'd0,   8'h00, 1'b1, 1'b1, 3'd0};
    vecs[8]  = '{4'b0001, 4'b0001, 10'd12,  8'h77, 4'b0000, 1'b1, 10'd12,  8'h77, 1'b0, 1'b0, 3'd0};
    vecs[9]  = '{4'b0000, 4'b0000, 10'd0,   8'h00, 4'b0000, 1'b0, 10'd0,   8'h00, 1'b0, 1'b0, 3'd0};
    vecs[10] = '{4'b0100, 4'b0000, 10'd512, 8'hAA, 4'b0100, 1'b0, 10'd0,   8'h00, 1'b0, 1'b1, 3'd2};
    vecs[11] = '{4'b0000, 4'b0000, 10'd0,   8'h00, 4'b0100, 1'b0, 10'd0,   8'h00, 1'b0, 1'b1, 3'd2};
    vecs[12] = '{4'b0100, 4'b0000, 10'd1,   8'h01, 4'b0100, 1'b1, 10'd1,   8'h01, 1'b0, 1'b1, 3'd2};
    vecs[13] = '{4'b0100, 4'b0100, 10'd512, 8'hAA, 4'b0000, 1'b1, 10'd512, 8'hAA, 1'b0, 1'b0, 3'd2};
    vecs[14] = '{4'b0000, 4'b0000, 10'd0,   8'h00, 4'b0000, 1'b0, 10'd0,   8'h00, 1'b0, 1'b0, 3'd2};

    exp_rot = '{3'd3, 3'd0, 3'd2, 3'd3, 3'd0, 3'd2};

    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    req_last  = '0;
    blackout  = 1'b0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_we",       write_en, 0);
    chk("rst_waddr",    write_addr, 0);
    chk("rst_wdata",    write_data, 0);
    chk("rst_ready",    req_ready, 0);
    chk("rst_grant",    grant_id, 0);
    chk("rst_busy",     busy, 0);
    chk("rst_bo_busy",  blackout_busy, 0);
    chk("rst_err",      err_addr, 0);
    rst = 1'b0;

    // Table: single burst, illegal addresses, boundary addresses, idle gap
    for (int i = 0; i < 15; i++) begin
      req_valid = vecs[i].valid;
      req_last  = vecs[i].last;
      for (int r = 0; r < 4; r++) begin
        req_addr[r] = vecs[i].addr;
        req_data[r] = vecs[i].data;
      end
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), req_ready, vecs[i].ready);
      chk($sformatf("vec%0d_we", i), write_en, vecs[i].we);
      chk($sformatf("vec%0d_err", i), err_addr, vecs[i].err);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      chk($sformatf("vec%0d_grant", i), grant_id, vecs[i].grant);
      chk($sformatf("vec%0d_bo_busy", i), blackout_busy, 0);
      if (vecs[i].we) begin
        chk($sformatf("vec%0d_waddr", i), write_addr, vecs[i].waddr);
        chk($sformatf("vec%0d_wdata", i), write_data, vecs[i].wdata);
      end
    end

    // Rotation: requesters 0, 2, 3 continuously valid with 2-byte bursts
    req_valid = 4'b1101;
    req_last  = '0;
    for (int r = 0; r < 4; r++) begin
      req_addr[r] = 10'(100 + r);
      req_data[r] = 8'(r);
      cnt[r] = 0;
    end
    pend = '0;
    grants = 0;
    wcount = 0;
    prev_busy = busy;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      for (int r = 0; r < 4; r++)
        if (pend[r]) cnt[r] = (cnt[r] == 1) ? 0 : 1;
      if (write_en) wcount++;
      if (busy && !prev_busy) begin
        if (grants < 6) got[grants] = grant_id;
        grants++;
      end
      prev_busy = busy;
      if (grants >= 6 && !busy) begin
        req_valid = '0;
        break;
      end
      for (int r = 0; r < 4; r++) req_last[r] = (cnt[r] == 1);
      pend = req_ready & req_valid;
    end
    chk("rot_grants", grants, 6);
    for (int k = 0; k < 6; k++) chk($sformatf("rot_grant%0d", k), got[k], exp_rot[k]);
    chk("rot_writes", wcount, 12);
    @(negedge clk);
    chk("rot_quiet_we", write_en, 0);
    chk("rot_quiet_busy", busy, 0);

    // Blackout pulsed mid-burst of requester 1 while requester 2 waits
    req_last = '0;
    req_valid = 4'b0010;
    req_addr[1] = 10'd20;
    req_data[1] = 8'h11;
    @(negedge clk);
    chk("bo_pre_grant", grant_id, 1);
    req_valid = 4'b0110;
    req_addr[2] = 10'd30;
    req_data[2] = 8'h22;
    req_last[2] = 1'b1;
    blackout = 1'b1;
    @(negedge clk);
    blackout = 1'b0;
    chk("bo_busy_rise", blackout_busy, 1);
    chk("bo_b1_we", write_en, 1);
    chk("bo_b1_addr", write_addr, 20);
    chk("bo_b1_busy", busy, 1);
    req_addr[1] = 10'd21;
    req_data[1] = 8'h12;
    req_last[1] = 1'b1;
    @(negedge clk);
    chk("bo_b2_we", write_en, 1);
    chk("bo_b2_addr", write_addr, 21);
    chk("bo_b2_data", write_data, 8'h12);
    chk("bo_burst_done_busy", busy, 0);
    chk("bo_pending_busy", blackout_busy, 1);
    req_valid = 4'b0100;
    req_last[1] = 1'b0;
    @(negedge clk);
    chk("bo_entry_busy", busy, 1);
    chk("bo_entry_ready", req_ready, 0);
    chk("bo_entry_we", write_en, 0);
    chk("bo_entry_bo_busy", blackout_busy, 1);
    sweep_bad = 0;
    for (int k = 1; k <= 512; k++) begin
      blackout = (k == 100);
      @(negedge clk);
      if (!write_en || write_addr != 10'(k) || write_data != 8'h00 || req_ready != 4'b0000)
        sweep_bad++;
      if (k < 512 && !(busy && blackout_busy)) sweep_bad++;
    end
    blackout = 1'b0;
    chk("bo_sweep_bad", sweep_bad, 0);
    chk("bo_end_busy", busy, 0);
    chk("bo_end_bo_busy", blackout_busy, 0);
    @(negedge clk);
    chk("bo_next_grant", grant_id, 2);
    chk("bo_next_busy", busy, 1);
    chk("bo_next_ready", req_ready, 4'b0100);
    chk("bo_next_bo_busy", blackout_busy, 0);
    @(negedge clk);
    chk("bo_r2_we", write_en, 1);
    chk("bo_r2_addr", write_addr, 30);
    chk("bo_r2_data", write_data, 8'h22);
    req_valid = '0;
    req_last = '0;

    // Blackout and request in the same IDLE cycle, then reset at addr 200
    req_valid = 4'b0001;
    req_addr[0] = 10'd50;
    req_data[0] = 8'h44;
    req_last[0] = 1'b1;
    blackout = 1'b1;
    @(negedge clk);
    blackout = 1'b0;
    chk("same_busy", busy, 1);
    chk("same_ready", req_ready, 0);
    chk("same_bo_busy", blackout_busy, 1);
    chk("same_grant", grant_id, 2);
    found = 1'b0;
    for (int k = 0; k < 600 && !found; k++) begin
      @(negedge clk);
      if (write_en && write_addr == 10'd200) found = 1'b1;
    end
    chk("bo_reach_200", found, 1);
    rst = 1'b1;
    req_valid = 4'b1001;
    req_addr[3] = 10'd40;
    req_data[3] = 8'h33;
    req_last[3] = 1'b1;
    #1;
    chk("mid_rst_we", write_en, 0);
    chk("mid_rst_waddr", write_addr, 0);
    chk("mid_rst_wdata", write_data, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_grant", grant_id, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_bo_busy", blackout_busy, 0);
    chk("mid_rst_err", err_addr, 0);
    @(negedge clk);
    chk("mid_rst_we2", write_en, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_grant", grant_id, 0);
    chk("post_rst_busy", busy, 1);
    chk("post_rst_bo_busy", blackout_busy, 0);
    chk("post_rst_ready", req_ready, 4'b0001);

    // Granted requester 0 goes quiet; grant revoked after 256 idle cycles
    req_valid = 4'b1000;
    n = 0;
    stray = 0;
    do begin
      @(negedge clk);
      n++;
      if (write_en) stray++;
    end while (busy && n < 400);
    chk("timeout_cycles", n, 256);
    chk("timeout_stray_we", stray, 0);
    chk("timeout_busy", busy, 0);
    @(negedge clk);
    chk("timeout_next_grant", grant_id, 3);
    chk("timeout_next_busy", busy, 1);
    chk("timeout_next_ready", req_ready, 4'b1000);
    @(negedge clk);
    chk("timeout_r3_we", write_en, 1);
    chk("timeout_r3_addr", write_addr, 40);
    chk("timeout_r3_data", write_data, 8'h33);
    chk("timeout_r3_busy", busy, 0);
    req_valid = '0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmx_write_arbiter.md
# dmx_write_arbiter

Shares the single-byte channel write port of the DMX512 transmitter among NUM_REQ requesters (console UI, network bridge, scene player, etc.). It grants whole bursts round-robin and range-checks every channel address. It also provides a priority blackout command that zeroes channels 1..512. The block sits directly in front of the transmitter's write_addr/write_data/write_en inputs.

## Interface
- NUM_REQ, default 4: number of requesters (2..8).
- TIMEOUT, default 256: cycles a granted requester may hold valid low before its grant is revoked.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_addr  in  NUM_REQ x 10  channel address; 1..512 legal.
- req_data  in  NUM_REQ x 8  channel value.
- req_last  in  NUM_REQ  marks the final byte of a burst.
- req_ready  out  NUM_REQ  byte accepted when valid and ready are both high.
- blackout  in  1  single-cycle request to zero all channels.
- blackout_busy  out  1  high while blackout is pending or running.
- write_addr  out  10  to transmitter write port.
- write_data  out  8  to transmitter write port.
- write_en  out  1  to transmitter write port; one byte per cycle.
- grant_id  out  3  index of the current or last grant.
- busy  out  1  high in every state except IDLE.
- err_addr  out  1  one-cycle pulse when a byte with an illegal address is accepted.

## Operation
- States:
  - IDLE: arbitrate.
  - BURST: grant held by one requester.
  - BLACKOUT: zero sweep.
- IDLE transitions:
  - If blackout is pending, go to BLACKOUT. Blackout has priority over all requesters.
  - Otherwise, if any req_valid is high, pick the first valid index searching upward (with wrap) from rr_ptr+1. Register it into grant_id and go to BURST.
- BURST:
  - req_ready[grant_id] = 1; all other ready bits are 0. Ready is combinational from state and grant.
  - On each transfer with an address in 1..512, drive write_en=1 with that addr/data on the next cycle.
  - A transfer with address 0 or >512 is still accepted. It produces no write_en; it pulses err_addr on the next cycle.
  - A transfer with req_last=1 sets rr_ptr=grant_id and returns to IDLE.
  - The idle counter resets on every transfer and increments while req_valid[grant_id]=0.
  - When the idle counter reaches TIMEOUT, revoke the grant: set rr_ptr=grant_id and go to IDLE without a write.
- BLACKOUT:
  - Counter runs 1..512. Each cycle emits write_en=1, write_addr=count, write_data=0.
  - After address 512 is written, go to IDLE.
  - req_ready is all 0.
- Blackout pending flag:
  - Set by a blackout pulse in IDLE or BURST.
  - Cleared on entry to BLACKOUT.
  - Pulses arriving during BLACKOUT are ignored.
- A blackout requested during BURST waits for that burst to finish (last byte or timeout). It then runs before any new grant.
- Arithmetic: address comparisons are unsigned 10-bit; the blackout counter is 10-bit and never wraps past 512.

## Timing
- Reset values:
  - All-zero: write_en, write_addr, write_data, req_ready, grant_id, busy, blackout_busy, err_addr.
  - rr_ptr = NUM_REQ-1, so requester 0 wins the first arbitration.
  - State is IDLE.
- Arbitration latency: valid seen in IDLE at cycle N gives grant and ready at N+1. The earliest first byte is accepted at N+1.
- Write latency: write_en/addr/data are registered, appearing one cycle after the accepting handshake.
- Throughput: one byte per cycle within a burst.
- Gap after req_last: a minimum of 1 IDLE cycle before the next grant.
- Blackout: blackout_busy rises the cycle after the pulse. Writes occupy 512 consecutive cycles, starting the cycle after entry to BLACKOUT. blackout_busy falls with the IDLE return.
- Reset mid-burst or mid-blackout aborts immediately. No further write_en is issued, and the pending blackout is lost.
- Simultaneous events:
  - A blackout pulse in the same IDLE cycle as req_valid: blackout wins.
  - All requesters valid: strict rotation, one full burst each.

## Structure
- dmx_pkg holds DMX_CHANNELS=512, DMX_ADDR_W=10, the arbiter state enum (IDLE, BURST, BLACKOUT), and the address-legal check function.
- Sub-module dmx_rr_arbiter is combinational: it takes the valid vector and rr_ptr and returns the winner index and an any-valid flag.

## Test plan
- Single requester 1 sends a 3-byte burst to addrs 5,6,7 with data 0x10,0x20,0x30 and last on the third byte. Required: three write_en pulses with matching addr/data, one cycle after each handshake; grant_id=1.
- Requesters 0, 2 and 3 hold valid continuously with 2-byte bursts. Required: grants in order 0,2,3,0,2,… with ≥1 IDLE cycle between bursts.
- Requester 0 sends addrs 0, 513, 12. Required: all three accepted; err_addr pulses twice; only addr 12 produces write_en.
- Blackout pulsed mid-burst of requester 1, with requester 2 valid. Required: requester 1 burst completes, then 512 zero writes to addrs 1..512, then requester 2 is granted.
- Granted requester drops valid for 256 cycles. Required: grant revoked, busy=0, and the next valid requester is granted; no spurious write_en.
- Reset asserted during blackout at addr 200. Required: write_en=0 immediately, and all outputs at their reset values.
